mem_stage: RTL

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM register and the write-back stage. It performs loads and stores over a request/acknowledge data-memory port. While an access is outstanding it stalls the upstream pipeline. It owns the MEM/WB pipeline register and drives the 5-bit control bundle and 69-bit data bundle that write-back consumes.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_stage_dmst_align.sv | 51 +++++
 rtl/mem_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-access stage: bit positions inside the
// EX/MEM control bundle, field positions inside the EX/MEM data bundle,
// widths of the bundles handed to write-back, and the stage FSM encoding.
// -----------------------------------------------------------------------------
package mem_pkg;

   // MEM_CTRL = {memRead, memWrite, regWrite, memToReg, isDMByte, isDMHalf, isLOADS}
   localparam int MEM_CTRL_W   = 7;
   localparam int IDX_MEM_READ = 6;
   localparam int IDX_MEM_WRITE = 5;
   localparam int IDX_REG_WRITE = 4;
   localparam int IDX_MEM_TO_REG = 3;
   localparam int IDX_DM_BYTE  = 2;
   localparam int IDX_DM_HALF  = 1;
   localparam int IDX_LOADS    = 0;

   // MEM_DATA = {rw[4:0], EXout[31:0], storeData[31:0]}
   localparam int MEM_DATA_W   = 69;
   localparam int RW_LSB       = 64;
   localparam int EXOUT_LSB    = 32;
   localparam int SDATA_LSB    = 0;

   // Bundles consumed by write-back and by EX forwarding
   localparam int WB_CTRL_W    = 5;
   localparam int WB_DATA_W    = 69;
   localparam int BACK_W       = 38;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

   // Word-aligned address for the data-memory port.
   function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
      return {byte_addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_stage_dmst_align.sv
// -----------------------------------------------------------------------------
// dmst_align
// Combinational store-lane steering for the data-memory port. Produces the
// byte enables and the lane-replicated write data for byte, half and word
// stores. Loads always read the full word (all enables set); sub-word
// extraction happens in write-back using EXout[1:0].
//
// Ports
//   i_addr_lo     in   2   EXout[1:0], byte offset within the word
//   i_is_byte     in   1   byte access
//   i_is_half     in   1   halfword access
//   i_mem_write   in   1   access is a store
//   i_store_data  in  32   register value to be stored
//   o_be          out  4   byte enables
//   o_wdata       out 32   replicated store data (0 for loads)
// -----------------------------------------------------------------------------
module dmst_align
   import mem_pkg::*;
(
   input  logic [1:0]  i_addr_lo,
   input  logic        i_is_byte,
   input  logic        i_is_half,
   input  logic        i_mem_write,
   input  logic [31:0] i_store_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata
);

   logic [3:0] w_byte_be;

   assign w_byte_be = 4'b0001 << i_addr_lo;

   always_comb begin
      o_be    = 4'b1111;
      o_wdata = 32'h0000_0000;
      if (i_mem_write) begin
         if (i_is_byte) begin
            o_be    = w_byte_be;
            o_wdata = {4{i_store_data[7:0]}};
         end else if (i_is_half) begin
            // address bit 0 is ignored for halfwords
            o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_store_data[15:0]}};
         end else begin
            o_be    = 4'b1111;
            o_wdata = i_store_data;
         end
      end
   end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage between the EX/MEM register and write-back. Issues one
// load or store at a time over a registered request/acknowledge port, stalls
// upstream while the access is outstanding, and owns the MEM/WB register.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no access outstanding; non-memory ops pass to MEM/WB in 1 cycle,
//         | a memory op stalls and launches dm_req on the next edge
//   BUSY  | dm_req held with latched attributes; waiting for dm_ack
//
// Ports
//   clk          in   1   pipeline clock
//   rst          in   1   asynchronous reset, active low
//   in_valid     in   1   EX/MEM holds a valid instruction
//   MEM_CTRL     in   7   {memRead, memWrite, regWrite, memToReg,
//                          isDMByte, isDMHalf, isLOADS}
//   MEM_DATA     in  69   {rw, EXout, storeData}
//   dm_req       out  1   registered memory request
//   dm_we        out  1   1 = store
//   dm_addr      out 32   word-aligned address
//   dm_be        out  4   byte enables
//   dm_wdata     out 32   lane-replicated store data
//   dm_ack       in   1   access completes this cycle
//   dm_rdata     in  32   raw read word (valid with dm_ack on loads)
//   o_MEM_stall  out  1   hold EX/MEM and earlier stages
//   o_MEM_BACK   out 38   {regWrite & in_valid & !memRead, EXout, rw}
//   o_WB_CTRL    out  5   {regWrite, memToReg, isDMByte, isDMHalf, isLOADS}
//   o_WB_DATA    out 69   {rw, EXout, Dout}
// -----------------------------------------------------------------------------
module mem_stage
   import mem_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [MEM_CTRL_W-1:0] MEM_CTRL,
   input  logic [MEM_DATA_W-1:0] MEM_DATA,
   output logic                  dm_req,
   output logic                  dm_we,
   output logic [31:0]           dm_addr,
   output logic [3:0]            dm_be,
   output logic [31:0]           dm_wdata,
   input  logic                  dm_ack,
   input  logic [31:0]           dm_rdata,
   output logic                  o_MEM_stall,
   output logic [BACK_W-1:0]     o_MEM_BACK,
   output logic [WB_CTRL_W-1:0]  o_WB_CTRL,
   output logic [WB_DATA_W-1:0]  o_WB_DATA
);

   mem_state_t r_state;
   mem_state_t w_next_state;

   logic                 r_dm_req;
   logic                 r_dm_we;
   logic [31:0]          r_dm_addr;
   logic [3:0]           r_dm_be;
   logic [31:0]          r_dm_wdata;
   logic [WB_CTRL_W-1:0] r_wb_ctrl;
   logic [WB_DATA_W-1:0] r_wb_data;

   logic        w_mem_read;
   logic        w_mem_write;
   logic        w_reg_write;
   logic        w_mem_op;
   logic [4:0]  w_rw;
   logic [31:0] w_exout;
   logic [31:0] w_store_data;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_dout;
   logic [WB_CTRL_W-1:0] w_wb_ctrl_in;

   logic w_stall;
   logic w_issue;
   logic w_complete;
   logic w_wb_load;

   // ---------------------------------------------------------------------
   // Bundle decode
   // ---------------------------------------------------------------------
   assign w_mem_read   = MEM_CTRL[IDX_MEM_READ];
   assign w_mem_write  = MEM_CTRL[IDX_MEM_WRITE];
   assign w_reg_write  = MEM_CTRL[IDX_REG_WRITE];
   assign w_rw         = MEM_DATA[RW_LSB +: 5];
   assign w_exout      = MEM_DATA[EXOUT_LSB +: 32];
   assign w_store_data = MEM_DATA[SDATA_LSB +: 32];

   // memWrite wins when both memRead and memWrite are set
   assign w_mem_op = in_valid & (w_mem_read | w_mem_write);

   // A bubble presents an all-zero control bundle to write-back.
   assign w_wb_ctrl_in = in_valid ? MEM_CTRL[WB_CTRL_W-1:0] : '0;

   // Raw memory word only for a completing load; stores and ALU ops carry 0.
   assign w_dout = ((r_state == BUSY) && !w_mem_write) ? dm_rdata : 32'h0000_0000;

   // Loads that are still in flight cannot be forwarded, hence !memRead.
   assign o_MEM_BACK = {w_reg_write & in_valid & ~w_mem_read, w_exout, w_rw};

   // ---------------------------------------------------------------------
   // Store lane steering
   // ---------------------------------------------------------------------
   dmst_align u_dmst_align (
      .i_addr_lo    (w_exout[1:0]),
      .i_is_byte    (MEM_CTRL[IDX_DM_BYTE]),
      .i_is_half    (MEM_CTRL[IDX_DM_HALF]),
      .i_mem_write  (w_mem_write),
      .i_store_data (w_store_data),
      .o_be         (w_be),
      .o_wdata      (w_wdata)
   );

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_stall      = 1'b0;
      w_issue      = 1'b0;
      w_complete   = 1'b0;
      w_wb_load    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_mem_op) begin
               w_stall      = 1'b1;
               w_issue      = 1'b1;
               w_next_state = BUSY;
            end else begin
               w_wb_load    = 1'b1;
            end
         end
         BUSY: begin
            w_stall = ~dm_ack;
            if (dm_ack) begin
               w_complete   = 1'b1;
               w_wb_load    = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign o_MEM_stall = w_stall;

   // ---------------------------------------------------------------------
   // Request registers: attributes latched at issue and held through BUSY
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dm_req   <= 1'b0;
         r_dm_we    <= 1'b0;
         r_dm_addr  <= 32'h0000_0000;
         r_dm_be    <= 4'h0;
         r_dm_wdata <= 32'h0000_0000;
      end else if (w_issue) begin
         r_dm_req   <= 1'b1;
         r_dm_we    <= w_mem_write;
         r_dm_addr  <= word_addr(w_exout);
         r_dm_be    <= w_be;
         r_dm_wdata <= w_wdata;
      end else if (w_complete) begin
         r_dm_req   <= 1'b0;
      end
   end

   assign dm_req   = r_dm_req;
   assign dm_we    = r_dm_we;
   assign dm_addr  = r_dm_addr;
   assign dm_be    = r_dm_be;
   assign dm_wdata = r_dm_wdata;

   // ---------------------------------------------------------------------
   // MEM/WB register: every cycle not loading an instruction loads a bubble
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_ctrl <= '0;
         r_wb_data <= '0;
      end else if (w_wb_load) begin
         r_wb_ctrl <= w_wb_ctrl_in;
         r_wb_data <= {w_rw, w_exout, w_dout};
      end else begin
         r_wb_ctrl <= '0;
         r_wb_data <= '0;
      end
   end

   assign o_WB_CTRL = r_wb_ctrl;
   assign o_WB_DATA = r_wb_data;

endmodule
